// File: rtl/reaction_timer.sv
// Reaction-time game controller: waits for a random delay, lights the go LED,
// and measures ticks until the synchronized player press, tracking the best time.
module reaction_timer #(
    parameter int unsigned MAX_MS   = 9999,
    parameter int unsigned RESULT_W = 14
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                random_finish,
    input  logic                button,
    output logic                led_go,
    output logic [RESULT_W-1:0] reaction_ms,
    output logic [RESULT_W-1:0] best_ms,
    output logic                result_valid,
    output logic                false_start,
    output logic                timeout
);

    localparam logic [RESULT_W-1:0] MAX_V = RESULT_W'(MAX_MS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RND,
        GO,
        DONE,
        FOUL
    } state_t;

    state_t state;
    state_t state_next;

    logic btn_sync1;
    logic btn_sync2;
    logic btn_edge;
    logic start_d;
    logic armed;
    logic press_pulse;
    logic start_rise;

    logic [RESULT_W-1:0] count;
    logic [RESULT_W-1:0] count_next;
    logic [RESULT_W-1:0] reaction_next;
    logic [RESULT_W-1:0] best_next;
    logic                valid_next;
    logic                foul_next;
    logic                timeout_next;
    logic                led_go_next;

    // Button synchronizer plus edge flop; start delay and re-arm tracking.
    // armed stays low after reset until start has been seen low, so a start
    // held through reset is not mistaken for a fresh rise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
            btn_edge  <= 1'b0;
            start_d   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            btn_sync1 <= button;
            btn_sync2 <= btn_sync1;
            btn_edge  <= btn_sync2;
            start_d   <= start;
            if (!start) begin
                armed <= 1'b1;
            end
        end
    end

    assign press_pulse = btn_sync2 & ~btn_edge;
    assign start_rise  = start & ~start_d;

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state;
        count_next    = count;
        reaction_next = reaction_ms;
        best_next     = best_ms;
        valid_next    = result_valid;
        foul_next     = false_start;
        timeout_next  = timeout;

        unique case (state)
            IDLE: begin
                if (start_rise && armed) begin
                    state_next   = WAIT_RND;
                    valid_next   = 1'b0;
                    foul_next    = 1'b0;
                    timeout_next = 1'b0;
                end
            end
            WAIT_RND: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (press_pulse) begin
                    state_next = FOUL;
                    foul_next  = 1'b1;
                end else if (random_finish) begin
                    state_next = GO;
                    count_next = '0;
                end
            end
            GO: begin
                if (!start) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (press_pulse) begin
                    state_next    = DONE;
                    reaction_next = count;
                    valid_next    = 1'b1;
                    timeout_next  = 1'b0;
                    if (count < best_ms) begin
                        best_next = count;
                    end
                end else if (count == MAX_V) begin
                    state_next    = DONE;
                    reaction_next = MAX_V;
                    valid_next    = 1'b0;
                    timeout_next  = 1'b1;
                end else begin
                    count_next = count + RESULT_W'(1);
                end
            end
            DONE, FOUL: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        led_go_next = (state_next == GO);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            led_go       <= 1'b0;
            reaction_ms  <= '0;
            best_ms      <= MAX_V;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            led_go       <= led_go_next;
            reaction_ms  <= reaction_next;
            best_ms      <= best_next;
            result_valid <= valid_next;
            false_start  <= foul_next;
            timeout      <= timeout_next;
        end
    end

endmodule
